ahb_sram_ctrl: RTL and testbench

AHB_SRAM_CTRL -- requirements
Module: ahb_sram_ctrl

---
 rtl/ahb_sram_pkg.sv | 33 +++
 rtl/ahb_sram_bank_dec.sv | 41 ++++
 rtl/ahb_sram_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_ahb_sram_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_sram_pkg.sv
// ahb_sram_pkg: shared FSM state type, AHB HTRANS encodings and a helper for
// the bank-select width. Optional feature macro: SRAM_CTRL_RD_BYPASS_EN
// (adds the BYPASS state used by the read-after-write bypass path).
package ahb_sram_pkg;

    // AHB-lite HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Wait counter is wide enough for the largest wait setting (15)
    localparam int CNT_W = 4;

    // Controller FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_WAIT = 3'd1,
        ST_WR_DONE = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RD_DONE = 3'd4
`ifdef SRAM_CTRL_RD_BYPASS_EN
        ,
        ST_BYPASS  = 3'd5
`endif
    } state_t;

    // Number of address bits used for bank select (0 for a single bank)
    function automatic int bank_bits(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

endpackage

// File: rtl/ahb_sram_bank_dec.sv
// ahb_sram_bank_dec: bank select for the SRAM controller. Decodes the top
// address bits into a one-hot chip enable and muxes the read data slice of
// the latched bank out of the concatenated SRAM output bus.
module ahb_sram_bank_dec
    import ahb_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int WORD_WIDTH = 8,
    parameter int NUM_BANKS  = 4,
    localparam int BANK_BITS = bank_bits(NUM_BANKS),
    localparam int BANK_W    = (BANK_BITS == 0) ? 1 : BANK_BITS
) (
    input  logic [ADDR_WIDTH-1:0]           addr,
    input  logic [BANK_W-1:0]               rd_bank,
    input  logic [NUM_BANKS*WORD_WIDTH-1:0] dout_bus,
    output logic [BANK_W-1:0]               bank,
    output logic [NUM_BANKS-1:0]            ce,
    output logic [WORD_WIDTH-1:0]           dout
);

    // A single bank has no select bits: everything maps to bank 0
    generate
        if (BANK_BITS == 0) begin : g_one_bank
            assign bank = '0;
        end else begin : g_multi_bank
            assign bank = addr[ADDR_WIDTH-1 -: BANK_BITS];
        end
    endgenerate

    // One-hot chip enable for the addressed bank
    always_comb begin
        ce       = '0;
        ce[bank] = 1'b1;
    end

    // Read data slice of the bank latched for the current data phase
    always_comb begin
        dout = dout_bus[int'(rd_bank)*WORD_WIDTH +: WORD_WIDTH];
    end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// ahb_sram_ctrl: AHB-lite slave in front of a banked synchronous SRAM.
// Writes stall for WRITE_WAIT cycles and strobe sram_we low in WR_DONE;
// reads stall for READ_WAIT cycles and return data in RD_DONE.
// Optional macro SRAM_CTRL_RD_BYPASS_EN: remembers the last completed write
// and answers a read of that exact address in one zero-wait BYPASS cycle.
//
// Handshake: a transfer is taken at a rising edge when hsel=1, htrans is
// NONSEQ/SEQ and hready=1. hready is low for the wait cycles of that
// transfer's data phase and high in the DONE/BYPASS cycle, where the next
// transfer may already be presented (back-to-back).
module ahb_sram_ctrl
    import ahb_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int WORD_WIDTH = 8,
    parameter int NUM_BANKS  = 4,
    parameter int WRITE_WAIT = 1,
    parameter int READ_WAIT  = 2,
    localparam int BANK_BITS = bank_bits(NUM_BANKS),
    localparam int BANK_W    = (BANK_BITS == 0) ? 1 : BANK_BITS,
    localparam int IN_W      = ADDR_WIDTH - BANK_BITS
) (
    input  logic                            hclk,
    input  logic                            hreset,
    input  logic                            hsel,
    input  logic [1:0]                      htrans,
    input  logic                            hwrite,
    input  logic [ADDR_WIDTH-1:0]           haddr,
    input  logic [WORD_WIDTH-1:0]           hwdata,
    output logic [WORD_WIDTH-1:0]           hrdata,
    output logic                            hready,
    output logic                            sram_clk,
    output logic [IN_W-1:0]                 sram_addr,
    output logic [WORD_WIDTH-1:0]           sram_din,
    output logic                            sram_we,
    output logic [NUM_BANKS-1:0]            sram_ce,
    input  logic [NUM_BANKS*WORD_WIDTH-1:0] sram_dout,
    output state_t                          fsm_state
);

    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_WAIT - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic                    sram_we_q;
    logic [BANK_W-1:0]       bank_q;
    logic                    xfer_valid;
    logic [BANK_W-1:0]       dec_bank;
    logic [NUM_BANKS-1:0]    dec_ce;
    logic [WORD_WIDTH-1:0]   dout_sel;

    assign sram_clk  = hclk;
    assign fsm_state = state;

    // The registered strobe is also gated by reset so a reset landing in
    // WR_DONE cannot let the SRAM commit the aborted write at that edge.
    assign sram_we = sram_we_q | hreset;

    // NONSEQ and SEQ both start a transfer; IDLE and BUSY never do
    assign xfer_valid = hsel && hready &&
                        ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

    ahb_sram_bank_dec #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORD_WIDTH (WORD_WIDTH),
        .NUM_BANKS  (NUM_BANKS)
    ) u_bank_dec (
        .addr     (haddr),
        .rd_bank  (bank_q),
        .dout_bus (sram_dout),
        .bank     (dec_bank),
        .ce       (dec_ce),
        .dout     (dout_sel)
    );

`ifdef SRAM_CTRL_RD_BYPASS_EN
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] rec_addr;
    logic [WORD_WIDTH-1:0] rec_data;
    logic                  rec_valid;
    logic                  byp_hit;
    logic [WORD_WIDTH-1:0] byp_data;

    // Bypass lookup; a write finishing this very cycle is newer than the record
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = rec_data;
        if (state == ST_WR_DONE && addr_q == haddr) begin
            byp_hit  = 1'b1;
            byp_data = sram_din;
        end else if (rec_valid && rec_addr == haddr) begin
            byp_hit = 1'b1;
        end
    end
`endif

    // Transfer sequencing; the FSM owns every AHB/SRAM output register
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            hready    <= 1'b1;
            sram_we_q <= 1'b1;
            sram_ce   <= '0;
            sram_addr <= '0;
            sram_din  <= '0;
            hrdata    <= '0;
            bank_q    <= '0;
`ifdef SRAM_CTRL_RD_BYPASS_EN
            addr_q    <= '0;
            rec_addr  <= '0;
            rec_data  <= '0;
            rec_valid <= 1'b0;
`endif
        end else begin
            case (state)
                ST_WR_WAIT: begin
                    // Write data arrives in the first data-phase cycle
                    if (cnt == '0) begin
                        sram_din <= hwdata;
                    end
                    if (cnt == WR_LAST) begin
                        state     <= ST_WR_DONE;
                        cnt       <= '0;
                        hready    <= 1'b1;
                        sram_we_q <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RD_WAIT: begin
                    // The SRAM output is settled by the last wait cycle
                    if (cnt == RD_LAST) begin
                        state  <= ST_RD_DONE;
                        cnt    <= '0;
                        hready <= 1'b1;
                        hrdata <= dout_sel;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // IDLE, WR_DONE, RD_DONE and BYPASS all have an open address phase
                default: begin
                    sram_we_q <= 1'b1;
                    cnt       <= '0;
`ifdef SRAM_CTRL_RD_BYPASS_EN
                    if (state == ST_WR_DONE) begin
                        rec_addr  <= addr_q;
                        rec_data  <= sram_din;
                        rec_valid <= 1'b1;
                    end
`endif
                    if (xfer_valid) begin
                        // The state itself remembers the transfer direction
                        sram_addr <= haddr[IN_W-1:0];
                        bank_q    <= dec_bank;
`ifdef SRAM_CTRL_RD_BYPASS_EN
                        addr_q    <= haddr;
                        if (!hwrite && byp_hit) begin
                            state   <= ST_BYPASS;
                            hready  <= 1'b1;
                            sram_ce <= '0;
                            hrdata  <= byp_data;
                        end else
`endif
                        if (hwrite) begin
                            state   <= ST_WR_WAIT;
                            hready  <= 1'b0;
                            sram_ce <= dec_ce;
                        end else begin
                            state   <= ST_RD_WAIT;
                            hready  <= 1'b0;
                            sram_ce <= dec_ce;
                        end
                    end else begin
                        state   <= ST_IDLE;
                        hready  <= 1'b1;
                        sram_ce <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// tb_ahb_sram_ctrl: directed bench for ahb_sram_ctrl with default parameters
// (6-bit address, 8-bit words, 4 banks, write wait 1, read wait 2). Expected
// values are hand-computed; read-back data goes through an expected queue.
// Builds with or without SRAM_CTRL_RD_BYPASS_EN.
module tb_ahb_sram_ctrl;
    import ahb_sram_pkg::*;

    localparam int AW  = 6;
    localparam int WW  = 8;
    localparam int NB  = 4;
    localparam int W_W = 1;
    localparam int R_W = 2;

    logic           hclk = 1'b0;
    logic           hreset;
    logic           hsel;
    logic [1:0]     htrans;
    logic           hwrite;
    logic [AW-1:0]  haddr;
    logic [WW-1:0]  hwdata;
    logic [WW-1:0]  hrdata;
    logic           hready;
    logic           sram_clk;
    logic [3:0]     sram_addr;
    logic [WW-1:0]  sram_din;
    logic           sram_we;
    logic [NB-1:0]  sram_ce;
    logic [NB*WW-1:0] sram_dout;
    state_t         fsm_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [WW-1:0] exp_q[$];

    int            waits;
    logic          we_low;
    logic [NB-1:0] ce_wait;

    ahb_sram_ctrl #(
        .ADDR_WIDTH (AW),
        .WORD_WIDTH (WW),
        .NUM_BANKS  (NB),
        .WRITE_WAIT (W_W),
        .READ_WAIT  (R_W)
    ) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hsel      (hsel),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .haddr     (haddr),
        .hwdata    (hwdata),
        .hrdata    (hrdata),
        .hready    (hready),
        .sram_clk  (sram_clk),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_we   (sram_we),
        .sram_ce   (sram_ce),
        .sram_dout (sram_dout),
        .fsm_state (fsm_state)
    );

    // Clock
    always #5 hclk = ~hclk;

    // Overall time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, required finish");
        $fatal(1, "time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one transfer at posedge+1; returns at the negedge of its DONE cycle
    task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [WW-1:0] wdata,
                           output int w, output logic wl, output logic [NB-1:0] cw);
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        hwrite = wr;
        haddr  = addr;
        @(posedge hclk); #1;
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwdata = wdata;
        w  = 0;
        wl = 1'b0;
        cw = '0;
        @(negedge hclk);
        while (hready !== 1'b1 && w < 20) begin
            w++;
            cw = sram_ce;
            if (sram_we !== 1'b1) wl = 1'b1;
            @(negedge hclk);
        end
    endtask

    task automatic align;
        @(posedge hclk); #1;
    endtask

    logic [1:0] bad_trans [3];
    logic       bad_sel   [3];

    initial begin
        hreset    = 1'b1;
        hsel      = 1'b0;
        htrans    = HTRANS_IDLE;
        hwrite    = 1'b0;
        haddr     = '0;
        hwdata    = '0;
        sram_dout = {8'h33, 8'h22, 8'h5A, 8'h11};

        // Reset, then three idle cycles
        repeat (2) @(posedge hclk);
        #1 hreset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge hclk);
            check($sformatf("idle_hready_%0d", i), hready, 1'b1);
        end
        check("rst_we", sram_we, 1'b1);
        check("rst_ce", sram_ce, 4'b0000);
        check("rst_hrdata", hrdata, 8'h00);
        check("rst_addr", sram_addr, 4'h0);
        check("rst_din", sram_din, 8'h00);
        check("rst_state", fsm_state, ST_IDLE);
        align();

        // Requests that must not start a transfer
        bad_sel[0] = 1'b0; bad_trans[0] = HTRANS_NONSEQ;
        bad_sel[1] = 1'b1; bad_trans[1] = HTRANS_IDLE;
        bad_sel[2] = 1'b1; bad_trans[2] = HTRANS_BUSY;
        for (int i = 0; i < 3; i++) begin
            hsel = bad_sel[i]; htrans = bad_trans[i]; hwrite = 1'b1; haddr = 6'h13;
            @(posedge hclk);
            @(negedge hclk);
            check($sformatf("nox_hready_%0d", i), hready, 1'b1);
            check($sformatf("nox_ce_%0d", i), sram_ce, 4'b0000);
            hsel = 1'b0; htrans = HTRANS_IDLE;
            align();
        end

        // Write 0xA5 to 0x13: bank 1, in-bank address 3
        do_xfer(1'b1, 6'h13, 8'hA5, waits, we_low, ce_wait);
        check("wr_waits", waits, W_W);
        check("wr_no_early_we", we_low, 1'b0);
        check("wr_wait_ce", ce_wait, 4'b0010);
        check("wr_done_we", sram_we, 1'b0);
        check("wr_done_ce", sram_ce, 4'b0010);
        check("wr_done_addr", sram_addr, 4'h3);
        check("wr_done_din", sram_din, 8'hA5);
        check("wr_done_state", fsm_state, ST_WR_DONE);
        align();
        @(negedge hclk);
        check("wr_after_we", sram_we, 1'b1);
        check("wr_after_ce", sram_ce, 4'b0000);
        align();

        // Read 0x13 with bank 1 output 0x5A
`ifdef SRAM_CTRL_RD_BYPASS_EN
        exp_q.push_back(8'hA5);
        do_xfer(1'b0, 6'h13, 8'h00, waits, we_low, ce_wait);
        check("rd13_waits", waits, 0);
        check("rd13_ce", sram_ce, 4'b0000);
`else
        exp_q.push_back(8'h5A);
        do_xfer(1'b0, 6'h13, 8'h00, waits, we_low, ce_wait);
        check("rd13_waits", waits, R_W);
        check("rd13_ce", sram_ce, 4'b0010);
        check("rd13_addr", sram_addr, 4'h3);
`endif
        check("rd13_hready", hready, 1'b1);
        check("rd13_we", sram_we, 1'b1);
        check("rd13_data", hrdata, exp_q[0]);
        // hrdata must hold once the read is over, whatever the SRAM does
        sram_dout[15:8] = 8'hEE;
        align();
        @(negedge hclk);
        check("rd13_hold", hrdata, exp_q.pop_front());
        sram_dout[15:8] = 8'h5A;
        align();

        // Back-to-back: write 0x01 to 0x00, read 0x3F presented during WR_DONE
        hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 6'h00;
        align();
        hwrite = 1'b0; haddr = 6'h3F; hwdata = 8'h01;
        @(negedge hclk);
        check("b2b_wr_hready", hready, 1'b0);
        check("b2b_wr_ce", sram_ce, 4'b0001);
        @(negedge hclk);
        check("b2b_wrdone_we", sram_we, 1'b0);
        check("b2b_wrdone_ce", sram_ce, 4'b0001);
        check("b2b_wrdone_din", sram_din, 8'h01);
        check("b2b_wrdone_addr", sram_addr, 4'h0);
        align();
        hsel = 1'b0; htrans = HTRANS_IDLE;
        @(negedge hclk);
        check("b2b_rd_state", fsm_state, ST_RD_WAIT);
        check("b2b_rd_ce", sram_ce, 4'b1000);
        check("b2b_rd_addr", sram_addr, 4'hF);
        check("b2b_rd_we", sram_we, 1'b1);
        waits = 1;
        @(negedge hclk);
        while (hready !== 1'b1 && waits < 20) begin
            waits++;
            @(negedge hclk);
        end
        exp_q.push_back(8'h33);
        check("b2b_rd_waits", waits, R_W);
        check("b2b_rd_data", hrdata, exp_q.pop_front());
        align();

        // Write 0x77 to 0x05, then read 0x05 (bank 0 output is 0x11)
        do_xfer(1'b1, 6'h05, 8'h77, waits, we_low, ce_wait);
        check("w05_din", sram_din, 8'h77);
        align();
`ifdef SRAM_CTRL_RD_BYPASS_EN
        exp_q.push_back(8'h77);
        do_xfer(1'b0, 6'h05, 8'h00, waits, we_low, ce_wait);
        check("r05_waits", waits, 0);
        check("r05_ce", sram_ce, 4'b0000);
        check("r05_state", fsm_state, ST_BYPASS);
`else
        exp_q.push_back(8'h11);
        do_xfer(1'b0, 6'h05, 8'h00, waits, we_low, ce_wait);
        check("r05_waits", waits, R_W);
        check("r05_wait_ce", ce_wait, 4'b0001);
        check("r05_ce", sram_ce, 4'b0001);
`endif
        check("r05_data", hrdata, exp_q.pop_front());
        align();

        // Reset during WR_WAIT aborts the write
        hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 6'h10;
        align();
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 8'h99; hreset = 1'b1;
        @(negedge hclk);
        check("rstw_wait_state", fsm_state, ST_WR_WAIT);
        check("rstw_wait_we", sram_we, 1'b1);
        align();
        hreset = 1'b0;
        @(negedge hclk);
        check("rstw_state", fsm_state, ST_IDLE);
        check("rstw_hready", hready, 1'b1);
        check("rstw_we", sram_we, 1'b1);
        check("rstw_ce", sram_ce, 4'b0000);
        check("rstw_hrdata", hrdata, 8'h00);
        check("rstw_din", sram_din, 8'h00);
        align();
        @(negedge hclk);
        check("rstw_late_we", sram_we, 1'b1);
        align();

        // Reset during WR_DONE must suppress the write strobe in that cycle
        do_xfer(1'b1, 6'h2A, 8'h3C, waits, we_low, ce_wait);
        check("rstd_pre_we", sram_we, 1'b0);
        hreset = 1'b1;
        #1;
        check("rstd_we_gated", sram_we, 1'b1);
        align();
        hreset = 1'b0;
        @(negedge hclk);
        check("rstd_state", fsm_state, ST_IDLE);
        check("rstd_addr", sram_addr, 4'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
